mux_rr: RTL and testbench

Parametrised N-channel multiplexer with a valid/ready handshake on every input and on the output, a registered output stage, and two selection modes: fixed select (a registered successor to the 2:1 mux) or round-robin arbitration across requesting channels. It sits between several producers and one consumer and forwards one word per cycle at full throughput.

---
 rtl/mux_rr.sv | 83 ++++++++
 tb/tb_mux_rr.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr.sv
// N-channel valid/ready multiplexer with a registered output stage.
// Selection is either a fixed channel index or round-robin across requesters.
module mux_rr #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  localparam int SELW = (N > 2) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic [N*WIDTH-1:0]   in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_sel
);

  localparam logic [SELW-1:0] LAST  = SELW'(N - 1);
  localparam logic [SELW:0]   N_EXT = (SELW + 1)'(N);

  logic [SELW-1:0]  ptr;
  logic             accept;
  logic             grant_valid;
  logic [SELW-1:0]  grant_idx;
  logic [SELW-1:0]  cand;
  logic [WIDTH-1:0] chan [N];

  assign accept = !out_valid || out_ready;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_chan
      assign chan[gi] = in_data[gi*WIDTH +: WIDTH];
      // rst_n gating keeps every ready low while reset is held
      assign in_ready[gi] = rst_n && accept && grant_valid && (grant_idx == SELW'(gi));
    end
  endgenerate

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = ptr;
    if (!mode) begin
      if (({1'b0, sel} < N_EXT) && in_valid[sel]) begin
        grant_valid = 1'b1;
        grant_idx   = sel;
      end
    end else begin
      // Walk ptr, ptr+1, ... modulo N; the first requester found wins
      for (int k = 0; k < N; k++) begin
        if (!grant_valid && in_valid[cand]) begin
          grant_valid = 1'b1;
          grant_idx   = cand;
        end
        cand = (cand == LAST) ? '0 : cand + SELW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (accept) begin
      if (grant_valid) begin
        out_valid <= 1'b1;
        out_data  <= chan[grant_idx];
        out_sel   <= grant_idx;
        if (mode) begin
          ptr <= (grant_idx == LAST) ? '0 : grant_idx + SELW'(1);
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_rr.sv
// Scoreboard bench for mux_rr: a reference model predicts grants and output
// words; predicted words are queued on transfer and compared at the output.
module tb_mux_rr;
  localparam int WIDTH = 8;
  localparam int N     = 4;
  localparam int SELW  = 2;

  logic                 clk;
  logic                 rst_n;
  logic                 mode;
  logic [SELW-1:0]      sel;
  logic [N-1:0]         in_valid;
  logic [N-1:0]         in_ready;
  logic [N*WIDTH-1:0]   in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_data;
  logic [SELW-1:0]      out_sel;

  mux_rr #(.WIDTH(WIDTH), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sel(out_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  int               m_sel;
  int               m_ptr;
  logic [WIDTH-1:0] q_data[$];
  int               q_sel[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic int model_grant();
    int idx;
    if (!mode) return in_valid[sel] ? int'(sel) : -1;
    for (int k = 0; k < N; k++) begin
      idx = (m_ptr + k) % N;
      if (in_valid[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_sel   = 0;
    m_ptr   = 0;
    q_data.delete();
    q_sel.delete();
  endtask

  // Called just after a negedge with inputs already driven
  task automatic cycle();
    int g;
    logic acc;
    logic [N-1:0] er;
    bit pushed;
    logic [WIDTH-1:0] d;
    #1;
    acc = !m_valid || out_ready;
    g   = model_grant();
    er  = '0;
    if (acc && g >= 0) er[g] = 1'b1;
    check_val("in_ready", 32'(in_ready), 32'(er));
    pushed = 1'b0;
    @(posedge clk);
    if (acc && g >= 0) begin
      d = WIDTH'(in_data >> (g * WIDTH));
      q_data.push_back(d);
      q_sel.push_back(g);
      m_valid = 1'b1;
      m_data  = d;
      m_sel   = g;
      if (mode) m_ptr = (g + 1) % N;
      pushed = 1'b1;
    end else if (acc) begin
      m_valid = 1'b0;
    end
    #1;
    check_val("out_valid", 32'(out_valid), 32'(m_valid));
    if (pushed) begin
      check_val("out_data", 32'(out_data), 32'(q_data.pop_front()));
      check_val("out_sel", 32'(out_sel), 32'(q_sel.pop_front()));
    end else if (m_valid) begin
      check_val("hold_data", 32'(out_data), 32'(m_data));
      check_val("hold_sel", 32'(out_sel), 32'(m_sel));
    end
    $display("t=%0t mode=%0d sel=%0d in_valid=%b out_ready=%0d -> out_valid=%0d out_sel=%0d out_data=0x%0h",
             $time, mode, sel, in_valid, out_ready, out_valid, out_sel, out_data);
    @(negedge clk);
  endtask

  initial begin
    rst_n     = 1'b0;
    mode      = 1'b1;
    sel       = '0;
    in_valid  = '1;
    in_data   = {8'h44, 8'h33, 8'h22, 8'h11};
    out_ready = 1'b1;
    model_reset();
    #3;
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_out_data", 32'(out_data), 32'd0);
    check_val("rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // fixed select
    mode = 1'b0; sel = 2'd2;
    cycle();
    check_val("fixed_data", 32'(out_data), 32'h33);
    check_val("fixed_sel", 32'(out_sel), 32'd2);
    sel = 2'd1; in_valid = 4'b1101;
    cycle();
    check_val("fixed_nogrant", 32'(out_valid), 32'd0);

    // round-robin sweep
    mode = 1'b1; in_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      in_data = {8'h40 + 8'(i), 8'h30 + 8'(i), 8'h20 + 8'(i), 8'h10 + 8'(i)};
      cycle();
      check_val("sweep_sel", 32'(out_sel), 32'(i % N));
    end

    // sparse requests with wrap: ptr -> 3, then 3,1,3
    in_valid = 4'b0100;
    cycle();
    in_valid = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_val("sparse_sel", 32'(out_sel), (i == 1) ? 32'd1 : 32'd3);
    end
    in_valid = 4'b1111;
    cycle();
    check_val("sparse_ptr0", 32'(out_sel), 32'd0);

    // backpressure
    mode = 1'b0; sel = 2'd1; in_data = {8'h44, 8'h33, 8'h22, 8'h11};
    cycle();
    out_ready = 1'b0; sel = 2'd3;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_val("bp_data", 32'(out_data), 32'h22);
    end
    out_ready = 1'b1;
    cycle();
    check_val("bp_replace", 32'(out_data), 32'h44);

    // mode switch: ptr 2 survives mode-0 transfers
    mode = 1'b1; in_valid = 4'b0010;
    cycle();
    mode = 1'b0; sel = 2'd0; in_valid = 4'b1111;
    cycle();
    cycle();
    mode = 1'b1;
    cycle();
    check_val("mode_sw_grant", 32'(out_sel), 32'd2);

    // asynchronous reset mid-stream
    #2;
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_valid", 32'(out_valid), 32'd0);
    check_val("mid_rst_data", 32'(out_data), 32'd0);
    check_val("mid_rst_sel", 32'(out_sel), 32'd0);
    check_val("mid_rst_ready", 32'(in_ready), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    check_val("post_rst_grant", 32'(out_sel), 32'd0);

    // random traffic
    for (int i = 0; i < 60; i++) begin
      mode      = 1'($urandom_range(0, 1));
      sel       = SELW'($urandom_range(0, N - 1));
      in_valid  = N'($urandom_range(0, (1 << N) - 1));
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = (N*WIDTH)'($urandom());
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
